// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared period counter, per-channel double-buffered duty.
// Optional center-aligned counting is enabled by defining PWM_CENTER_EN.
//
// dir_down | meaning (PWM_CENTER_EN builds only)
// ---------+-----------------------------------------------
// 0        | counting up towards top_act (reset / idle)
// 1        | counting down towards 0; reload happens at 0
module pwm_multi #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CH_W     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [WIDTH-1:0]    top,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [WIDTH:0]      wr_duty,
    output logic [CHANNELS-1:0] pwm,
    output logic                sync
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] top_act;
    logic [WIDTH:0]   shadow [CHANNELS];
    logic [WIDTH:0]   active [CHANNELS];
    logic             wr_hit;
    logic             wrap;
    logic             load;
    logic             sync_nxt;

    assign wr_hit = wr_en && (int'(wr_ch) < CHANNELS);
    assign wrap   = (cnt == top_act);

`ifdef PWM_CENTER_EN
    logic dir_down;

    // Reload only at the bottom turnaround so both halves of a period share one duty.
    assign load     = !en || (dir_down && (cnt == '0));
    assign sync_nxt = en && !dir_down && (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            dir_down <= 1'b0;
        end else if (!en) begin
            cnt      <= '0;
            dir_down <= 1'b0;
        end else if (!dir_down) begin
            if (wrap) begin
                dir_down <= 1'b1;
            end else begin
                cnt <= cnt + WIDTH'(1);
            end
        end else begin
            if (cnt == '0) begin
                dir_down <= 1'b0;
            end else begin
                cnt <= cnt - WIDTH'(1);
            end
        end
    end
`else
    assign load     = !en || wrap;
    assign sync_nxt = en && (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + WIDTH'(1);
        end
    end
`endif

    // Per-channel decode keeps out-of-range indices from ever addressing the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_hit && (wr_ch == CH_W'(i))) begin
                    shadow[i] <= wr_duty;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_act <= '1;
            for (int i = 0; i < CHANNELS; i++) begin
                active[i] <= '0;
            end
        end else if (load) begin
            top_act <= top;
            for (int i = 0; i < CHANNELS; i++) begin
                active[i] <= shadow[i];
            end
        end
    end

    // Compare at WIDTH+1 bits so a duty above top_act gives a constant-high output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm  <= '0;
            sync <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                pwm[i] <= en && ({1'b0, cnt} < active[i]);
            end
            sync <= sync_nxt;
        end
    end

endmodule
